// File: rtl/adc_fifo_pkg.sv
// Shared types for the ADC capture FIFO: default widths, the stored sample word
// and the fill-state encoding.
package adc_fifo_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_TAG_W  = 4;

    typedef struct packed {
        logic [ADC_TAG_W-1:0]  tag;
        logic [ADC_DATA_W-1:0] data;
    } adc_sample_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fill_state_e;

endpackage

// File: rtl/adc_sample_fifo_if.sv
// Valid/ready read stream from the capture FIFO to the FIR filter.
// The master side is the FIFO, the slave side is the consumer.
interface adc_sample_fifo_if
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int TAG_W  = ADC_TAG_W
);
    logic              rd_valid_out;
    logic              rd_ready_in;
    logic [DATA_W-1:0] rd_data_out;
    logic [TAG_W-1:0]  rd_tag_out;

    modport master (
        output rd_valid_out,
        output rd_data_out,
        output rd_tag_out,
        input  rd_ready_in
    );

    modport slave (
        input  rd_valid_out,
        input  rd_data_out,
        input  rd_tag_out,
        output rd_ready_in
    );
endinterface

// File: rtl/adc_fifo_mem.sv
// DEPTH-entry sample store: one synchronous write port and one asynchronous
// read port so the head word falls through without a read cycle.
module adc_fifo_mem
    import adc_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  adc_sample_t   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output adc_sample_t   o_rdata
);

    adc_sample_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC capture FIFO: edge-detects end-of-conversion, stores {seq, data} in a FWFT
// FIFO, flags full/overflow and a fill-level interrupt. ADC_FIFO_OVF_CNT_EN adds ovf_cnt_out.
module adc_sample_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int TAG_W  = ADC_TAG_W,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              eoc_in,
    input  logic [DATA_W-1:0] adc_data_in,
    input  logic [TAG_W-1:0]  seq_in,
    input  logic              clr_in,
    input  logic [CNT_W-1:0]  thresh_in,
    adc_sample_fifo_if.master rd_if,
    output logic              full_out,
    output logic              empty_out,
    output logic [CNT_W-1:0]  level_out,
    output logic              thresh_irq_out,
    output logic              ovf_out
`ifdef ADC_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt_out
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic             r_eoc_q;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    fill_state_e      r_state;
    fill_state_e      w_state_next;
    logic             r_irq;
    logic             r_ovf;
    logic             w_wr_req;
    logic             w_pop;
    logic             w_wr_acc;
    logic             w_drop;
    logic             w_empty;
    logic             w_full;
    adc_sample_t      w_wr_sample;
    adc_sample_t      w_rd_sample;

    assign w_empty  = (r_state == EMPTY);
    assign w_full   = (r_state == FULL);
    assign w_wr_req = eoc_in & ~r_eoc_q;
    assign w_pop    = ~w_empty & rd_if.rd_ready_in;
    // A pop in the same cycle frees the slot, so a write while full is still accepted.
    assign w_wr_acc = w_wr_req & ~clr_in & (~w_full | w_pop);
    assign w_drop   = w_wr_req & ~clr_in & w_full & ~w_pop;

    assign w_wr_sample.tag  = seq_in;
    assign w_wr_sample.data = adc_data_in;

    adc_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clk_in),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_sample),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_sample)
    );

    always_comb begin
        w_count_next = r_count;
        if (clr_in) begin
            w_count_next = '0;
        end else if (w_wr_acc && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_wr_acc && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            EMPTY: begin
                if (w_wr_acc) w_state_next = PARTIAL;
            end
            PARTIAL: begin
                if (w_count_next == CNT_W'(DEPTH)) w_state_next = FULL;
                else if (w_count_next == '0)       w_state_next = EMPTY;
            end
            FULL: begin
                if (w_pop && !w_wr_acc) w_state_next = PARTIAL;
            end
            default: w_state_next = EMPTY;
        endcase
        if (clr_in) w_state_next = EMPTY;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_eoc_q  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_irq    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_eoc_q <= eoc_in;
            r_count <= w_count_next;
            r_irq   <= (thresh_in != '0) && (w_count_next >= thresh_in);
            if (clr_in) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_drop)   r_ovf    <= 1'b1;
            end
        end
    end

`ifdef ADC_FIFO_OVF_CNT_EN
    logic [7:0] r_ovf_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ovf_cnt <= '0;
        end else if (clr_in) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt_out = r_ovf_cnt;
`endif

    // Head word is forced to zero while empty so stale array contents never leak out.
    assign rd_if.rd_valid_out = ~w_empty;
    assign rd_if.rd_data_out  = w_empty ? '0 : w_rd_sample.data;
    assign rd_if.rd_tag_out   = w_empty ? '0 : w_rd_sample.tag;

    assign full_out       = w_full;
    assign empty_out      = w_empty;
    assign level_out      = r_count;
    assign thresh_irq_out = r_irq;
    assign ovf_out        = r_ovf;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for full, overflow, flush and reset corners.
module tb_adc_sample_fifo;

    logic        clk_in;
    logic        rst_in;
    logic        eoc_in;
    logic [11:0] adc_data_in;
    logic [3:0]  seq_in;
    logic        clr_in;
    logic [4:0]  thresh_in;
    logic        full_out;
    logic        empty_out;
    logic [4:0]  level_out;
    logic        thresh_irq_out;
    logic        ovf_out;
`ifdef ADC_FIFO_OVF_CNT_EN
    logic [7:0]  ovf_cnt_out;
`endif

    int n_pass  = 0;
    int n_total = 0;

    adc_sample_fifo_if #(.DATA_W(12), .TAG_W(4)) rd_if ();

    adc_sample_fifo #(
        .DATA_W (12),
        .TAG_W  (4),
        .DEPTH  (16),
        .CNT_W  (5)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .eoc_in         (eoc_in),
        .adc_data_in    (adc_data_in),
        .seq_in         (seq_in),
        .clr_in         (clr_in),
        .thresh_in      (thresh_in),
        .rd_if          (rd_if.master),
        .full_out       (full_out),
        .empty_out      (empty_out),
        .level_out      (level_out),
        .thresh_irq_out (thresh_irq_out),
        .ovf_out        (ovf_out)
`ifdef ADC_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt_out    (ovf_cnt_out)
`endif
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        eoc;
        logic [11:0] data;
        logic [3:0]  seq;
        logic        ready;
        logic        clr;
        logic [4:0]  thresh;
        logic        valid_e;
        logic [11:0] data_e;
        logic [3:0]  tag_e;
        logic [4:0]  level_e;
        logic        full_e;
        logic        empty_e;
        logic        ovf_e;
        logic        irq_e;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int eoc, input int data, input int seq, input int ready,
                                input int thresh, input int valid_e, input int data_e,
                                input int tag_e, input int level_e, input int full_e,
                                input int empty_e, input int irq_e);
        vec_t v;
        v.eoc     = 1'(eoc);
        v.data    = 12'(data);
        v.seq     = 4'(seq);
        v.ready   = 1'(ready);
        v.clr     = 1'b0;
        v.thresh  = 5'(thresh);
        v.valid_e = 1'(valid_e);
        v.data_e  = 12'(data_e);
        v.tag_e   = 4'(tag_e);
        v.level_e = 5'(level_e);
        v.full_e  = 1'(full_e);
        v.empty_e = 1'(empty_e);
        v.ovf_e   = 1'b0;
        v.irq_e   = 1'(irq_e);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse(input int d, input logic ready);
        eoc_in            = 1'b1;
        adc_data_in       = 12'(d);
        seq_in            = 4'(d);
        rd_if.rd_ready_in = ready;
        tick();
        eoc_in            = 1'b0;
        rd_if.rd_ready_in = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in            = 1'b1;
        eoc_in            = 1'b0;
        adc_data_in       = '0;
        seq_in            = '0;
        clr_in            = 1'b0;
        thresh_in         = '0;
        rd_if.rd_ready_in = 1'b0;
        tick();
        tick();

        check("rst valid", 32'(rd_if.rd_valid_out), 32'd0);
        check("rst data",  32'(rd_if.rd_data_out),  32'd0);
        check("rst tag",   32'(rd_if.rd_tag_out),   32'd0);
        check("rst empty", 32'(empty_out),          32'd1);
        check("rst full",  32'(full_out),           32'd0);
        check("rst level", 32'(level_out),          32'd0);
        check("rst irq",   32'(thresh_irq_out),     32'd0);
        check("rst ovf",   32'(ovf_out),            32'd0);
        rst_in = 1'b0;
        tick();

        // eoc dat seq rdy thr | val dat tag lvl full empty irq
        vq.push_back(mk(1, 'hA5C, 2, 0, 0,  1, 'hA5C, 2, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++)
            vq.push_back(mk(1, 'h123, 5, 0, 0,  1, 'h123, 5, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 1, 0,  0, 0,     0, 0, 0, 1, 0));
        vq.push_back(mk(1, 'h001, 1, 0, 4,  1, 'h001, 1, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 0, 4,  1, 'h001, 1, 1, 0, 0, 0));
        vq.push_back(mk(1, 'h002, 2, 0, 4,  1, 'h001, 1, 2, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 0, 4,  1, 'h001, 1, 2, 0, 0, 0));
        vq.push_back(mk(1, 'h003, 3, 0, 4,  1, 'h001, 1, 3, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 0, 4,  1, 'h001, 1, 3, 0, 0, 0));
        vq.push_back(mk(1, 'h004, 4, 0, 4,  1, 'h001, 1, 4, 0, 0, 1));
        vq.push_back(mk(0, 0,     0, 1, 4,  1, 'h002, 2, 3, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 1, 4,  1, 'h003, 3, 2, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 1, 4,  1, 'h004, 4, 1, 0, 0, 0));
        vq.push_back(mk(0, 0,     0, 1, 4,  0, 0,     0, 0, 0, 1, 0));
        vq.push_back(mk(0, 0,     0, 1, 4,  0, 0,     0, 0, 0, 1, 0));

        foreach (vq[i]) begin
            eoc_in            = vq[i].eoc;
            adc_data_in       = vq[i].data;
            seq_in            = vq[i].seq;
            rd_if.rd_ready_in = vq[i].ready;
            clr_in            = vq[i].clr;
            thresh_in         = vq[i].thresh;
            tick();
            check($sformatf("v%0d valid", i), 32'(rd_if.rd_valid_out), 32'(vq[i].valid_e));
            check($sformatf("v%0d data", i),  32'(rd_if.rd_data_out),  32'(vq[i].data_e));
            check($sformatf("v%0d tag", i),   32'(rd_if.rd_tag_out),   32'(vq[i].tag_e));
            check($sformatf("v%0d level", i), 32'(level_out),          32'(vq[i].level_e));
            check($sformatf("v%0d full", i),  32'(full_out),           32'(vq[i].full_e));
            check($sformatf("v%0d empty", i), 32'(empty_out),          32'(vq[i].empty_e));
            check($sformatf("v%0d ovf", i),   32'(ovf_out),            32'(vq[i].ovf_e));
            check($sformatf("v%0d irq", i),   32'(thresh_irq_out),     32'(vq[i].irq_e));
        end
        eoc_in            = 1'b0;
        rd_if.rd_ready_in = 1'b0;
        thresh_in         = '0;
        tick();

        // Fill to full, then overflow with a 17th sample.
        for (int k = 1; k <= 16; k++) pulse(k, 1'b0);
        check("fill full",  32'(full_out),  32'd1);
        check("fill level", 32'(level_out), 32'd16);
        check("fill ovf",   32'(ovf_out),   32'd0);
        pulse(17, 1'b0);
        check("ovf flag",  32'(ovf_out),             32'd1);
        check("ovf level", 32'(level_out),           32'd16);
        check("ovf head",  32'(rd_if.rd_data_out),   32'd1);
        check("ovf tag",   32'(rd_if.rd_tag_out),    32'd1);
`ifdef ADC_FIFO_OVF_CNT_EN
        check("ovf cnt", 32'(ovf_cnt_out), 32'd1);
`endif
        clr_in = 1'b1;
        tick();
        clr_in = 1'b0;
        check("clr level", 32'(level_out),          32'd0);
        check("clr empty", 32'(empty_out),          32'd1);
        check("clr ovf",   32'(ovf_out),            32'd0);
        check("clr valid", 32'(rd_if.rd_valid_out), 32'd0);
`ifdef ADC_FIFO_OVF_CNT_EN
        check("clr ovf cnt", 32'(ovf_cnt_out), 32'd0);
`endif

        // Full with a simultaneous pop and write.
        for (int k = 1; k <= 16; k++) pulse(k, 1'b0);
        pulse(17, 1'b1);
        check("fullpop level", 32'(level_out), 32'd16);
        check("fullpop ovf",   32'(ovf_out),   32'd0);
        check("fullpop full",  32'(full_out),  32'd1);
        rd_if.rd_ready_in = 1'b1;
        for (int k = 2; k <= 17; k++) begin
            check($sformatf("drain %0d", k), 32'(rd_if.rd_data_out), 32'(k));
            tick();
        end
        rd_if.rd_ready_in = 1'b0;
        check("drain empty", 32'(empty_out), 32'd1);
        check("drain level", 32'(level_out), 32'd0);

        // Flush with five entries and a coincident eoc edge.
        for (int k = 1; k <= 5; k++) pulse(k, 1'b0);
        check("flush pre level", 32'(level_out), 32'd5);
        clr_in      = 1'b1;
        eoc_in      = 1'b1;
        adc_data_in = 12'h7FF;
        tick();
        clr_in = 1'b0;
        check("flush level", 32'(level_out), 32'd0);
        check("flush empty", 32'(empty_out), 32'd1);
        check("flush ovf",   32'(ovf_out),   32'd0);
        tick();
        check("flush held eoc", 32'(level_out), 32'd0);
        eoc_in = 1'b0;
        tick();

        // Asynchronous reset mid-fill, with eoc high across the release.
        for (int k = 1; k <= 3; k++) pulse(k, 1'b0);
        check("arst pre level", 32'(level_out), 32'd3);
        #2;
        rst_in      = 1'b1;
        eoc_in      = 1'b1;
        adc_data_in = 12'h0AB;
        seq_in      = 4'h3;
        #1;
        check("arst level", 32'(level_out),          32'd0);
        check("arst empty", 32'(empty_out),          32'd1);
        check("arst valid", 32'(rd_if.rd_valid_out), 32'd0);
        check("arst data",  32'(rd_if.rd_data_out),  32'd0);
        tick();
        rst_in = 1'b0;
        tick();
        check("rel level", 32'(level_out),         32'd1);
        check("rel data",  32'(rd_if.rd_data_out), 32'h0AB);
        check("rel tag",   32'(rd_if.rd_tag_out),  32'd3);
        eoc_in = 1'b0;
        tick();
        check("rel one write", 32'(level_out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
